// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file with write-first bypass and pending scoreboard
module reg_file_2r1w #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int PRELOAD  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic                rd_pend_a,
  output logic                rd_valid_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_pend_b,
  output logic                rd_valid_b,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic [NUM_REGS-1:0] pending
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PRE [8] = '{10, 1000, 100, 1, 10000, 0, 500, 5000};
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [DEPTH-1:0]  pend_d;
  logic              wr_ok, rsv_ok;
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS && !(ZERO_REG != 0 && a == '0);
  endfunction
  function automatic logic [DATA_W-1:0] init_val(input int i);
    return (PRELOAD == 0 || i > 7 || (ZERO_REG != 0 && i == 0)) ? '0 : DATA_W'(PRE[i % 8]);
  endfunction
  // write-first: a same-cycle write to the read address is returned
  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    return !live(a) ? '0 : (wr_ok && wr_addr == a) ? wr_data : mem[a];
  endfunction
  assign wr_ok  = wr_en && live(wr_addr);
  assign rsv_ok = rsv_en && live(rsv_addr);
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_pend
      if (i < NUM_REGS && !(ZERO_REG != 0 && i == 0)) begin : g_live
        assign pend_d[i] = (rsv_ok && rsv_addr == ADDR_W'(i)) ? 1'b1 :
                           (wr_ok && wr_addr == ADDR_W'(i)) ? 1'b0 : pending[i];
      end else begin : g_dead
        assign pend_d[i] = 1'b0;
      end
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) mem[k] <= init_val(k);
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      rd_data_a  <= '0;
      rd_pend_a  <= 1'b0;
      rd_valid_a <= 1'b0;
      rd_data_b  <= '0;
      rd_pend_b  <= 1'b0;
      rd_valid_b <= 1'b0;
    end else begin
      pending    <= pend_d[NUM_REGS-1:0];
      rd_valid_a <= rd_en_a;
      rd_valid_b <= rd_en_b;
      if (rd_en_a) begin
        rd_data_a <= rd_word(rd_addr_a);
        rd_pend_a <= pend_d[rd_addr_a];
      end
      if (rd_en_b) begin
        rd_data_b <= rd_word(rd_addr_b);
        rd_pend_b <= pend_d[rd_addr_b];
      end
    end
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: random + directed check of two configurations against a behavioural model
module tb_reg_file_2r1w;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, wr_en, rd_en_a, rd_en_b, rsv_en;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b, rsv_addr;
  logic [15:0] wr_data;
  logic [15:0] rda [2], rdb [2];
  logic pa [2], pb [2], va [2], vb [2];
  logic [7:0] pend0;
  logic [5:0] pend1;
  int n_tests = 0, n_fail = 0;
  int nr [2] = '{8, 6};
  bit zr [2] = '{0, 1};
  int pre [8] = '{10, 1000, 100, 1, 10000, 0, 500, 5000};
  logic [15:0] m_reg [2][8];
  bit m_pend [2][8];
  logic [15:0] m_da [2], m_db [2];
  bit m_pa [2], m_pb [2], m_va [2], m_vb [2];
  reg_file_2r1w u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .rd_pend_a(pa[0]), .rd_valid_a(va[0]),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]), .rd_pend_b(pb[0]), .rd_valid_b(vb[0]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pend0)
  );
  reg_file_2r1w #(.NUM_REGS(6), .ZERO_REG(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .rd_pend_a(pa[1]), .rd_valid_a(va[1]),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]), .rd_pend_b(pb[1]), .rd_valid_b(vb[1]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pend1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit live(input int k, input int a);
    return a < nr[k] && !(zr[k] && a == 0);
  endfunction
  task automatic cyc(input bit r, input bit we, input int wa, input int wd, input bit ea, input int aa,
                     input bit eb, input int ab, input bit rs, input int ra);
    logic [7:0] ev;
    rst = r; wr_en = we; wr_addr = 3'(wa); wr_data = 16'(wd);
    rd_en_a = ea; rd_addr_a = 3'(aa); rd_en_b = eb; rd_addr_b = 3'(ab);
    rsv_en = rs; rsv_addr = 3'(ra);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        for (int j = 0; j < 8; j++) begin
          m_pend[k][j] = 0;
          m_reg[k][j] = (zr[k] && j == 0) ? 16'd0 : 16'(pre[j]);
        end
        m_da[k] = 0; m_db[k] = 0; m_pa[k] = 0; m_pb[k] = 0; m_va[k] = 0; m_vb[k] = 0;
      end else begin
        if (we && live(k, wa)) begin
          m_reg[k][wa] = 16'(wd);
          m_pend[k][wa] = 0;
        end
        if (rs && live(k, ra)) m_pend[k][ra] = 1;
        m_va[k] = ea;
        m_vb[k] = eb;
        if (ea) begin
          m_da[k] = live(k, aa) ? m_reg[k][aa] : 16'd0;
          m_pa[k] = aa < nr[k] ? m_pend[k][aa] : 0;
        end
        if (eb) begin
          m_db[k] = live(k, ab) ? m_reg[k][ab] : 16'd0;
          m_pb[k] = ab < nr[k] ? m_pend[k][ab] : 0;
        end
      end
      ev = '0;
      for (int j = 0; j < nr[k]; j++) ev[j] = m_pend[k][j];
      check($sformatf("u%0d.rd_valid_a", k), 32'(va[k]), 32'(m_va[k]));
      check($sformatf("u%0d.rd_valid_b", k), 32'(vb[k]), 32'(m_vb[k]));
      check($sformatf("u%0d.rd_data_a", k), 32'(rda[k]), 32'(m_da[k]));
      check($sformatf("u%0d.rd_data_b", k), 32'(rdb[k]), 32'(m_db[k]));
      if (m_va[k]) check($sformatf("u%0d.rd_pend_a", k), 32'(pa[k]), 32'(m_pa[k]));
      if (m_vb[k]) check($sformatf("u%0d.rd_pend_b", k), 32'(pb[k]), 32'(m_pb[k]));
      check($sformatf("u%0d.pending", k), k ? 32'(pend1) : 32'(pend0), 32'(ev));
    end
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 'hBEEF, 1, 1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 1, 1, 6, 0, 0);
    check("tp1.a_1000", 32'(rda[0]), 1000);
    check("tp1.b_500", 32'(rdb[0]), 500);
    cyc(0, 1, 3, 'hAB, 1, 3, 0, 0, 0, 0);
    check("tp2.bypass", 32'(rda[0]), 'hAB);
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    cyc(0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    check("tp3.pend_a", 32'(pa[0]), 1);
    cyc(0, 1, 5, 'h1234, 0, 0, 1, 5, 0, 0);
    check("tp3.clear", 32'(pb[0]), 0);
    cyc(0, 1, 2, 7, 0, 0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 1, 2, 1, 2, 1, 2);
    check("tp4.keep", 32'(pend0[2]), 1);
    cyc(0, 1, 0, 'hFFFF, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
    check("tp5.zero", 32'(rda[1]), 0);
    cyc(0, 1, 7, 'h55, 1, 7, 0, 0, 1, 7);
    cyc(0, 0, 0, 0, 1, 7, 1, 6, 0, 0);
    cyc(1, 1, 1, 'hDEAD, 1, 1, 0, 0, 1, 3);
    cyc(0, 0, 0, 0, 1, 1, 1, 4, 0, 0);
    check("tp6.preload", 32'(rda[1]), 1000);
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 7),
          $urandom_range(0, 2) == 0, $urandom_range(0, 7));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised general-purpose register file for the 16-bit CPU datapath.
- Replaces the fixed 8x16 single-port register array with two synchronous read ports and one synchronous write port.
- Adds write-to-read bypass, a per-register pending scoreboard for hazard detection, an optional hard-wired zero register, and reset-time constant preload.
- Sits between instruction decode (read and reserve) and writeback (write).

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers, 2..64 (need not be a power of two).
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= NUM_REGS.
- ZERO_REG, 0, if 1 then register 0 reads as 0, ignores writes and is never pending.
- PRELOAD, 1, if 1 then reset loads the constant table, otherwise all zeros.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write register index
- wr_data  in  DATA_W  write data
- rd_en_a  in  1  port A read strobe
- rd_addr_a  in  ADDR_W  port A index
- rd_data_a  out  DATA_W  port A registered read data
- rd_pend_a  out  1  port A: register was pending at sample time
- rd_valid_a  out  1  port A: rd_data_a updated this cycle
- rd_en_b, rd_addr_b, rd_data_b, rd_pend_b, rd_valid_b: same as port A, for port B
- rsv_en  in  1  mark rsv_addr pending (decode issued a producer)
- rsv_addr  in  ADDR_W  register to reserve
- pending  out  NUM_REGS  live scoreboard vector

Behaviour:
- **Reset** (rst=1 at a clock edge):
  - All rd_data cleared to 0; rd_pend, rd_valid and pending cleared to 0.
  - With PRELOAD=1, registers 0..7 load 10, 1000, 100, 1, 10000, 0, 500, 5000, truncated to DATA_W. Registers 8 and up load 0.
  - ZERO_REG=1 forces register 0 to 0 regardless of PRELOAD.
  - rst overrides every strobe in the same cycle.
- **Write:** if wr_en=1 and wr_addr is in range (and not register 0 when ZERO_REG=1), the register takes wr_data at the edge. Out-of-range or zero-register writes are silently dropped.
- **Read latency:** 1 cycle.
  - If rd_en_x=1 at edge N, rd_data_x, rd_pend_x and rd_valid_x=1 are valid after edge N.
  - If rd_en_x=0, rd_data_x holds its previous value and rd_valid_x=0.
- **Bypass:** a read and a write to the same valid address in the same cycle returns the new wr_data (write-first). Both ports bypass independently. A read of register 0 with ZERO_REG=1 returns 0 even if written.
- **Out-of-range read:** returns 0 with rd_pend=0.
- **Scoreboard**, per register, at each edge:
  - rsv_en to that register sets pending.
  - Otherwise, a valid wr_en to that register clears pending.
  - Otherwise, pending holds.
  - Simultaneous reserve and write to the same register: the write updates data and pending stays 1, because the newer producer wins.
  - Reserving an already-pending register keeps it pending. No counting; a single outstanding producer per register is a system rule.
  - Out-of-range or zero-register reserves are ignored.
- **rd_pend_x timing:** reflects pending after the same-cycle write/reserve update. A read coincident with the clearing write returns the bypassed data with rd_pend=0. A read coincident with a reserve returns rd_pend=1.
- **Read-only sampling:** reads never alter state. Ports A and B may target the same register.
- **Implementation:** no combinational path from inputs to outputs except through the rd_* registers; pending is a direct register output.

Test Plan:
1. Reset with PRELOAD=1, then read A=1 and B=6 -> one cycle later rd_data_a=1000, rd_data_b=500, both rd_valid=1, both rd_pend=0, pending=0.
2. Write reg 3=0x00AB while reading A=3 in the same cycle -> rd_data_a=0x00AB next cycle (bypass). Read B=3 the following cycle -> 0x00AB.
3. rsv_en on reg 5, then read A=5 -> rd_pend_a=1, pending[5]=1. Write reg 5=0x1234 while reading B=5 -> rd_data_b=0x1234, rd_pend_b=0, pending[5]=0.
4. Same cycle: rsv_en=1 and wr_en=1 on reg 2 with data 7 -> reg 2=7 and pending[2] stays 1.
5. ZERO_REG=1: write reg 0=0xFFFF, rsv reg 0, read A=0 -> rd_data_a=0, rd_pend_a=0, pending[0]=0.
6. NUM_REGS=6, ADDR_W=3: write reg 7=0x55, read A=7 -> write dropped, rd_data_a=0. Assert rst mid-sequence with wr_en=1 -> preload values restored, pending=0, write ignored.
